// File: rtl/advanced_fifo_pkg.sv
// advanced_fifo_pkg: shared defaults, width helper and error-flag payload
// for the advanced FIFO and its storage.
package advanced_fifo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH = 4;

  // Bits needed to encode 'count' distinct values; never less than one bit.
  function automatic int unsigned width_for(input int unsigned count);
    return (count <= 1) ? 1 : $clog2(count);
  endfunction

  // Sticky error flags held by the controller.
  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_errors_t;

endpackage

// File: rtl/advanced_fifo_controller.sv
// advanced_fifo_controller: pointers, level, status and sticky error flags
// for the advanced FIFO, driving an external dual-port memory.
// Ports:
//   clock, resetn                       clock and synchronous active-low reset
//   flush                               discard all contents
//   write_enable/write_data             push request
//   read_enable                         pop request
//   clear_errors                        clear sticky flags
//   almost_full/empty_threshold         programmable thresholds
//   full/almost_full/empty/almost_empty status from registered level
//   level                               occupancy 0..DEPTH
//   overflow/underflow                  sticky error flags
//   read_data                           head word (from memory)
//   mem_*                               memory write/read port
module advanced_fifo_controller
  import advanced_fifo_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned DEPTH       = DEFAULT_DEPTH,
  localparam int unsigned DEPTH_LOG2  = width_for(DEPTH),
  localparam int unsigned LEVEL_WIDTH = width_for(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   write_enable,
  input  logic [WIDTH-1:0]       write_data,
  input  logic                   read_enable,
  input  logic                   clear_errors,
  input  logic [LEVEL_WIDTH-1:0] almost_full_threshold,
  input  logic [LEVEL_WIDTH-1:0] almost_empty_threshold,
  output logic                   full,
  output logic                   almost_full,
  output logic                   empty,
  output logic                   almost_empty,
  output logic [LEVEL_WIDTH-1:0] level,
  output logic                   overflow,
  output logic                   underflow,
  output logic [WIDTH-1:0]       read_data,
  output logic                   mem_write_enable,
  output logic [DEPTH_LOG2-1:0]  mem_write_address,
  output logic [WIDTH-1:0]       mem_write_data,
  output logic                   mem_read_enable,
  output logic [DEPTH_LOG2-1:0]  mem_read_address,
  input  logic [WIDTH-1:0]       mem_read_data
);

  logic [DEPTH_LOG2-1:0]  write_ptr;
  logic [DEPTH_LOG2-1:0]  read_ptr;
  logic [LEVEL_WIDTH-1:0] level_q;
  fifo_errors_t           errors_q;
  fifo_errors_t           errors_set_c;
  logic                   read_accept_c;
  logic                   write_accept_c;

  // Pointers wrap by compare so non-power-of-two depths work.
  function automatic logic [DEPTH_LOG2-1:0] next_ptr(input logic [DEPTH_LOG2-1:0] ptr);
    return (ptr == DEPTH_LOG2'(DEPTH - 1)) ? '0 : ptr + DEPTH_LOG2'(1);
  endfunction

  // Status and accept decode from the registered level only.
  always_comb begin
    empty          = (level_q == '0);
    full           = (level_q == LEVEL_WIDTH'(DEPTH));
    almost_full    = (level_q >= almost_full_threshold);
    almost_empty   = (level_q <= almost_empty_threshold);
    read_accept_c  = read_enable & ~empty & ~flush;
    // A pop in the same cycle frees the slot a full FIFO needs.
    write_accept_c = write_enable & (~full | read_accept_c) & ~flush;
    errors_set_c.overflow  = ~flush & write_enable & full & ~read_accept_c;
    errors_set_c.underflow = ~flush & read_enable & empty;
  end

  // Pointer, level and sticky-flag state.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      write_ptr <= '0;
      read_ptr  <= '0;
      level_q   <= '0;
      errors_q  <= '0;
    end else begin
      if (flush) begin
        write_ptr <= '0;
        read_ptr  <= '0;
        level_q   <= '0;
      end else begin
        if (write_accept_c) begin
          write_ptr <= next_ptr(write_ptr);
        end
        if (read_accept_c) begin
          read_ptr <= next_ptr(read_ptr);
        end
        case ({write_accept_c, read_accept_c})
          2'b10:   level_q <= level_q + LEVEL_WIDTH'(1);
          2'b01:   level_q <= level_q - LEVEL_WIDTH'(1);
          default: level_q <= level_q;
        endcase
      end
      // A new error in the same cycle as clear_errors wins.
      errors_q.overflow  <= (errors_q.overflow  & ~clear_errors) | errors_set_c.overflow;
      errors_q.underflow <= (errors_q.underflow & ~clear_errors) | errors_set_c.underflow;
    end
  end

  assign level             = level_q;
  assign overflow          = errors_q.overflow;
  assign underflow         = errors_q.underflow;
  assign mem_write_enable  = write_accept_c;
  assign mem_write_address = write_ptr;
  assign mem_write_data    = write_data;
  assign mem_read_enable   = ~empty;
  assign mem_read_address  = read_ptr;
  assign read_data         = mem_read_data;

endmodule

// File: rtl/simple_dual_port_ram.sv
// simple_dual_port_ram: one write port, one read port, single clock.
// Ports:
//   clock                               sole clock
//   write_enable/write_address/write_data  synchronous write port
//   read_enable/read_address            read port controls
//   read_data                           read word (combinational or registered)
module simple_dual_port_ram
  import advanced_fifo_pkg::*;
#(
  parameter int unsigned WIDTH           = DEFAULT_WIDTH,
  parameter int unsigned DEPTH           = DEFAULT_DEPTH,
  parameter bit          REGISTERED_READ = 1'b0,
  localparam int unsigned ADDR_WIDTH     = width_for(DEPTH)
) (
  input  logic                  clock,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [WIDTH-1:0]      write_data,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output logic [WIDTH-1:0]      read_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clock) begin
    if (write_enable) begin
      mem[write_address] <= write_data;
    end
  end

  // Read port: registered or plain combinational lookup.
  generate
    if (REGISTERED_READ) begin : g_registered_read
      logic [WIDTH-1:0] read_q;
      always_ff @(posedge clock) begin
        if (read_enable) begin
          read_q <= mem[read_address];
        end
      end
      assign read_data = read_q;
    end else begin : g_comb_read
      // Output forced to zero when not enabled so it is deterministic.
      assign read_data = read_enable ? mem[read_address] : '0;
    end
  endgenerate

endmodule

// File: rtl/advanced_fifo.sv
// advanced_fifo: single-clock FIFO with any depth >= 2, occupancy level,
// programmable almost-full/almost-empty thresholds, synchronous flush and
// sticky overflow/underflow flags.
// Ports:
//   clock, resetn                     clock and synchronous active-low reset
//   flush                             discard all contents this cycle
//   write_enable, write_data          push request and word
//   read_enable                       pop request
//   read_data                         head word, valid while empty is 0
//   full, almost_full, empty, almost_empty, level   occupancy status
//   almost_full/empty_threshold       programmable thresholds
//   overflow, underflow, clear_errors sticky error flags and their clear
module advanced_fifo
  import advanced_fifo_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned DEPTH       = DEFAULT_DEPTH,
  localparam int unsigned DEPTH_LOG2  = width_for(DEPTH),
  localparam int unsigned LEVEL_WIDTH = width_for(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   write_enable,
  input  logic [WIDTH-1:0]       write_data,
  output logic                   full,
  output logic                   almost_full,
  input  logic                   read_enable,
  output logic [WIDTH-1:0]       read_data,
  output logic                   empty,
  output logic                   almost_empty,
  output logic [LEVEL_WIDTH-1:0] level,
  input  logic [LEVEL_WIDTH-1:0] almost_full_threshold,
  input  logic [LEVEL_WIDTH-1:0] almost_empty_threshold,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clear_errors
);

  logic                  mem_write_enable;
  logic [DEPTH_LOG2-1:0] mem_write_address;
  logic [WIDTH-1:0]      mem_write_data;
  logic                  mem_read_enable;
  logic [DEPTH_LOG2-1:0] mem_read_address;
  logic [WIDTH-1:0]      mem_read_data;

  advanced_fifo_controller #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_controller (
    .clock                  (clock),
    .resetn                 (resetn),
    .flush                  (flush),
    .write_enable           (write_enable),
    .write_data             (write_data),
    .read_enable            (read_enable),
    .clear_errors           (clear_errors),
    .almost_full_threshold  (almost_full_threshold),
    .almost_empty_threshold (almost_empty_threshold),
    .full                   (full),
    .almost_full            (almost_full),
    .empty                  (empty),
    .almost_empty           (almost_empty),
    .level                  (level),
    .overflow               (overflow),
    .underflow              (underflow),
    .read_data              (read_data),
    .mem_write_enable       (mem_write_enable),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_read_enable        (mem_read_enable),
    .mem_read_address       (mem_read_address),
    .mem_read_data          (mem_read_data)
  );

  // Unregistered read so the head word is visible in the cycle it becomes head.
  simple_dual_port_ram #(
    .WIDTH           (WIDTH),
    .DEPTH           (DEPTH),
    .REGISTERED_READ (1'b0)
  ) u_ram (
    .clock         (clock),
    .write_enable  (mem_write_enable),
    .write_address (mem_write_address),
    .write_data    (mem_write_data),
    .read_enable   (mem_read_enable),
    .read_address  (mem_read_address),
    .read_data     (mem_read_data)
  );

endmodule

// File: tb/tb_advanced_fifo.sv
// tb_advanced_fifo: directed self-checking bench for advanced_fifo, DEPTH=5.
module tb_advanced_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned LW    = 3;

  logic          clock;
  logic          resetn;
  logic          flush;
  logic          write_enable;
  logic [7:0]    write_data;
  logic          full;
  logic          almost_full;
  logic          read_enable;
  logic [7:0]    read_data;
  logic          empty;
  logic          almost_empty;
  logic [LW-1:0] level;
  logic [LW-1:0] almost_full_threshold;
  logic [LW-1:0] almost_empty_threshold;
  logic          overflow;
  logic          underflow;
  logic          clear_errors;

  int checks;
  int failures;

  advanced_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clock                  (clock),
    .resetn                 (resetn),
    .flush                  (flush),
    .write_enable           (write_enable),
    .write_data             (write_data),
    .full                   (full),
    .almost_full            (almost_full),
    .read_enable            (read_enable),
    .read_data              (read_data),
    .empty                  (empty),
    .almost_empty           (almost_empty),
    .level                  (level),
    .almost_full_threshold  (almost_full_threshold),
    .almost_empty_threshold (almost_empty_threshold),
    .overflow               (overflow),
    .underflow              (underflow),
    .clear_errors           (clear_errors)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    write_enable = 1'b1;
    write_data   = d;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic pop();
    read_enable = 1'b1;
    tick();
    read_enable = 1'b0;
  endtask

  task automatic clear_flags();
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
  endtask

  task automatic test_reset();
    almost_full_threshold = 3'd0;
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL reset_almost_empty got=%b exp=1", almost_empty); end
    checks++; if (almost_full !== 1'b1) begin failures++; $display("FAIL reset_almost_full_thr0 got=%b exp=1", almost_full); end
    checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL reset_errors got=%b exp=00", {overflow, underflow}); end
    almost_full_threshold = 3'd4;
    #1;
    checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_almost_full_thr4 got=%b exp=0", almost_full); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 5; i++) begin
      push(8'(8'h11 + i));
      checks++; if (level !== 3'(i + 1)) begin failures++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, level, i + 1); end
      checks++; if (full !== (i == 4)) begin failures++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i == 4)); end
    end
    push(8'h16);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_set got=%b exp=1", overflow); end
    checks++; if (level !== 3'd5) begin failures++; $display("FAIL overflow_level got=%0d exp=5", level); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (read_data !== 8'(8'h11 + i)) begin failures++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, read_data, 8'(8'h11 + i)); end
      pop();
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL drain_underflow got=%b exp=0", underflow); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_sticky got=%b exp=1", overflow); end
    clear_flags();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL overflow_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_wrap();
    for (int i = 1; i <= 3; i++) push(8'(i));
    for (int i = 1; i <= 3; i++) begin
      checks++; if (read_data !== 8'(i)) begin failures++; $display("FAIL wrap_pre[%0d] got=%h exp=%h", i, read_data, 8'(i)); end
      pop();
    end
    for (int i = 0; i < 5; i++) push(8'(8'h20 + i));
    checks++; if (level !== 3'd5) begin failures++; $display("FAIL wrap_level got=%0d exp=5", level); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (read_data !== 8'(8'h20 + i)) begin failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, read_data, 8'(8'h20 + i)); end
      pop();
    end
    checks++; if ({empty, overflow, underflow} !== 3'b100) begin failures++; $display("FAIL wrap_end got=%b exp=100", {empty, overflow, underflow}); end
  endtask

  task automatic test_simul_full();
    logic [7:0] exp_q [5];
    exp_q = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h33};
    for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
    read_enable  = 1'b1;
    write_enable = 1'b1;
    write_data   = 8'h33;
    tick();
    read_enable  = 1'b0;
    write_enable = 1'b0;
    checks++; if (level !== 3'd5) begin failures++; $display("FAIL rw_full_level got=%0d exp=5", level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rw_full_overflow got=%b exp=0", overflow); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (read_data !== exp_q[i]) begin failures++; $display("FAIL rw_full_data[%0d] got=%h exp=%h", i, read_data, exp_q[i]); end
      pop();
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rw_full_empty got=%b exp=1", empty); end
  endtask

  task automatic test_underflow();
    read_enable  = 1'b1;
    write_enable = 1'b1;
    write_data   = 8'h44;
    tick();
    read_enable  = 1'b0;
    write_enable = 1'b0;
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL underflow_set got=%b exp=1", underflow); end
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL underflow_level got=%0d exp=1", level); end
    checks++; if (read_data !== 8'h44) begin failures++; $display("FAIL underflow_data got=%h exp=44", read_data); end
    // Clear while popping the last word: no new error, flag clears.
    clear_errors = 1'b1;
    read_enable  = 1'b1;
    tick();
    checks++; if ({underflow, empty} !== 2'b01) begin failures++; $display("FAIL underflow_clear got=%b exp=01", {underflow, empty}); end
    // Clear and a new underflow in the same cycle: set wins.
    tick();
    clear_errors = 1'b0;
    read_enable  = 1'b0;
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL clear_vs_set got=%b exp=1", underflow); end
    clear_flags();
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL underflow_clear2 got=%b exp=0", underflow); end
  endtask

  task automatic test_thresholds();
    almost_full_threshold  = 3'd4;
    almost_empty_threshold = 3'd1;
    for (int l = 0; l <= 5; l++) begin
      checks++; if ({level, almost_empty, almost_full} !== {3'(l), (l <= 1), (l >= 4)}) begin
        failures++; $display("FAIL thr_up[%0d] got=%b exp=%b", l, {level, almost_empty, almost_full}, {3'(l), (l <= 1), (l >= 4)});
      end
      if (l < 5) push(8'(l));
    end
    for (int l = 5; l >= 0; l--) begin
      checks++; if ({level, almost_empty, almost_full} !== {3'(l), (l <= 1), (l >= 4)}) begin
        failures++; $display("FAIL thr_down[%0d] got=%b exp=%b", l, {level, almost_empty, almost_full}, {3'(l), (l <= 1), (l >= 4)});
      end
      if (l > 0) pop();
    end
    // Requests alone never move status before an edge.
    write_enable = 1'b1;
    write_data   = 8'hA5;
    #2;
    checks++; if ({level, empty} !== {3'd0, 1'b1}) begin failures++; $display("FAIL no_comb_level got=%b exp=0001", {level, empty}); end
    tick();
    write_enable = 1'b0;
    checks++; if ({level, read_data} !== {3'd1, 8'hA5}) begin failures++; $display("FAIL write_latency got=%h exp=1a5", {level, read_data}); end
    // Threshold changes act combinationally.
    almost_full_threshold = 3'd1;
    #1;
    checks++; if (almost_full !== 1'b1) begin failures++; $display("FAIL thr_comb_af got=%b exp=1", almost_full); end
    almost_empty_threshold = 3'd0;
    #1;
    checks++; if (almost_empty !== 1'b0) begin failures++; $display("FAIL thr_comb_ae got=%b exp=0", almost_empty); end
    almost_full_threshold  = 3'd4;
    almost_empty_threshold = 3'd1;
    pop();
  endtask

  task automatic test_flush();
    pop();
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL flush_pre_underflow got=%b exp=1", underflow); end
    for (int i = 0; i < 3; i++) push(8'(8'h61 + i));
    flush        = 1'b1;
    write_enable = 1'b1;
    write_data   = 8'h99;
    tick();
    flush        = 1'b0;
    write_enable = 1'b0;
    checks++; if ({level, empty} !== {3'd0, 1'b1}) begin failures++; $display("FAIL flush_state got=%b exp=0001", {level, empty}); end
    checks++; if ({overflow, underflow} !== 2'b01) begin failures++; $display("FAIL flush_flags got=%b exp=01", {overflow, underflow}); end
    push(8'h77);
    checks++; if ({level, read_data} !== {3'd1, 8'h77}) begin failures++; $display("FAIL post_flush got=%h exp=177", {level, read_data}); end
    pop();
    clear_flags();
    flush       = 1'b1;
    read_enable = 1'b1;
    tick();
    flush       = 1'b0;
    read_enable = 1'b0;
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL flush_no_underflow got=%b exp=0", underflow); end
  endtask

  task automatic test_reset_mid();
    pop();
    push(8'h81);
    push(8'h82);
    resetn       = 1'b0;
    write_enable = 1'b1;
    write_data   = 8'h83;
    tick();
    resetn       = 1'b1;
    write_enable = 1'b0;
    checks++; if ({empty, full, level, almost_empty, almost_full} !== {1'b1, 1'b0, 3'd0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL reset_mid_status got=%b exp=1000010", {empty, full, level, almost_empty, almost_full});
    end
    checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL reset_mid_errors got=%b exp=00", {overflow, underflow}); end
  endtask

  initial begin
    checks                 = 0;
    failures               = 0;
    resetn                 = 1'b0;
    flush                  = 1'b0;
    write_enable           = 1'b0;
    write_data             = '0;
    read_enable            = 1'b0;
    clear_errors           = 1'b0;
    almost_full_threshold  = 3'd4;
    almost_empty_threshold = 3'd1;
    test_reset();
    test_fill_overflow();
    test_wrap();
    test_simul_full();
    test_underflow();
    test_thresholds();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
